dj8_io_responder: RTL and testbench
===================================

# dj8_io_responder

Memory-mapped I/O responder on the DJ8 CPU memory bus; the target-side end of the CPU's `address_out`/`data_out`/`we` store protocol and the read-data source for its `data_in` mux. Decodes an 8-byte register window at `BASE` and provides a transmit FIFO toward an output stream, a one-byte receive holding register from an input stream, and a prescaled 8-bit reload timer with interrupt. Sits beside RAM/ROM; the top-level read mux selects `rdata` when `hit` is high.

## Interface
- `BASE`, 16'hFF00: window base; must be 8-byte aligned.
- `TX_DEPTH`, 4: TX FIFO depth, power of two, 2..16.
- `PRESCALE`, 256: clock cycles per timer tick, >= 1.

- `clk` in 1: clock; all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 16: CPU `address_out`.
- `wdata` in 8: CPU `data_out`.
- `we` in 1: CPU write enable, active low.
- `hit` out 1: combinational, `address[15:3] == BASE[15:3]`.
- `rdata` out 8: combinational read data for `address[2:0]`; 0 when `hit` low.
- `tx_data` out 8: FIFO head byte.
- `tx_valid` out 1: FIFO non-empty.
- `tx_ready` in 1: sink accepts `tx_data` when high with `tx_valid`.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: incoming byte valid.
- `rx_ready` out 1: high when RX holding register empty.
- `irq` out 1: `timer_flag & irq_en`, registered source.

## Operation
- Store protocol: CPU drives `we` low for exactly one rising edge per store, with `address`/`wdata` stable across that edge. A write commits on every rising edge where `we==0 && hit`. No read strobe exists; reads are side-effect free.
- Register map (offset: read / write):
  - 0 TXDATA: reads 0 / push `wdata` into FIFO.
  - 1 STATUS: `{2'b0, tx_ovf, rx_full, tx_full, tx_empty, timer_flag, timer_en}` / write 1 to bit5 clears `tx_ovf`; other bits ignored.
  - 2 RXDATA: held byte (0 when empty) / ignored.
  - 3 RXACK: reads 0 / any write empties RX holding register.
  - 4 TRELOAD: reload value / sets reload and loads counter with `wdata`, clears prescaler.
  - 5 TCOUNT: current counter / ignored.
  - 6 TCTRL: `{5'b0, irq_en, 1'b0, timer_en}` / bit0 `timer_en`, bit2 `irq_en`, bit1=1 clears `timer_flag`.
  - 7: reads 0 / ignored.
- TX FIFO: pop on `tx_valid && tx_ready`. Push when full and no pop same cycle: byte dropped, `tx_ovf` set (sticky). Push when full with simultaneous pop: accepted. Push when empty: `tx_valid` high next cycle; no fall-through.
- RX: capture `rx_data` on `rx_valid && rx_ready`; `rx_full` set. `rx_ready = !rx_full`, so capture and RXACK never conflict.
- Timer: when `timer_en`, prescaler counts 0..PRESCALE-1; on wrap, counter decrements. Decrement from 1 to 0 sets `timer_flag`; counter at 0 on a tick reloads instead of decrementing. Reload value 0: flag set every tick. Clearing `timer_en` freezes prescaler and counter.
- Flag set and software clear on the same edge: set wins.

## Timing
- All write effects visible (in `rdata`, status, outputs) the cycle after the committing edge.
- `rdata`, `hit` purely combinational; valid within the same cycle as `address`.
- Reset values: FIFO empty (`tx_valid`=0, `tx_data`=0), `tx_ovf`=0, `rx_full`=0 (`rx_ready`=1), reload=0, counter=0, prescaler=0, `timer_en`=0, `irq_en`=0, `timer_flag`=0, `irq`=0.
- Reset assertion mid-store or mid-handshake: all state cleared immediately; a write pending on that edge is lost.
- TX throughput: one pop per cycle; one push per CPU store (at most one every 4 cycles).

## Test plan
- Reset: hold `reset_n`=0 -> `tx_valid`=0, `rx_ready`=1, `irq`=0; STATUS at 16'hFF01 reads 8'h04.
- TX: `tx_ready`=0, store 8'hA5, 8'h5A to 16'hFF00 -> `tx_valid`=1, `tx_data`=8'hA5; raise `tx_ready` -> A5 then 5A popped, `tx_valid`=0.
- Overflow: `tx_ready`=0, five stores with `TX_DEPTH`=4 -> STATUS bit5 and bit3 set, fifth byte absent on drain; write 8'h20 to STATUS -> bit5 clears.
- RX: `rx_valid`=1 with 8'h3C -> `rx_ready`=0, RXDATA reads 8'h3C; second byte 8'h77 not taken; store to 16'hFF03 -> `rx_ready`=1, 8'h77 captured next edge.
- Timer: `PRESCALE`=4, TRELOAD=2, TCTRL=8'h05 -> `timer_flag` and `irq` high after 8 cycles, counter reloads to 2; TCTRL=8'h07 on same edge as next set -> flag stays high.
- Non-hit: store to 16'hFEFF and 16'hFF08 -> no state change, `hit`=0, `rdata`=0.

Source files
------------

// File: rtl/dj8_io_responder.sv
// DJ8 memory-mapped I/O responder: 8-byte register window with TX FIFO,
// RX holding register and a prescaled reload timer with interrupt.
module dj8_io_responder #(
  parameter logic [15:0] BASE     = 16'hFF00,
  parameter int          TX_DEPTH = 4,
  parameter int          PRESCALE = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] address,
  input  logic [7:0]  wdata,
  input  logic        we,
  output logic        hit,
  output logic [7:0]  rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(TX_DEPTH);

  logic [7:0]    tx_mem_q [TX_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_full_q, rx_full_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic [7:0]    reload_q, reload_d;
  logic [7:0]    tcount_q, tcount_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          timer_en_q, timer_en_d;
  logic          irq_en_q, irq_en_d;
  logic          timer_flag_q, timer_flag_d;

  logic [2:0] offset;
  logic       wr_en, push_req, push_ok, pop, tx_full, tx_empty;
  logic       tick, flag_set;

  assign hit      = (address[15:3] == BASE[15:3]);
  assign offset   = address[2:0];
  assign wr_en    = !we && hit;
  assign tx_full  = (count_q == DEPTH_C);
  assign tx_empty = (count_q == '0);
  assign tx_valid = !tx_empty;
  assign pop      = tx_valid && tx_ready;
  assign push_req = wr_en && (offset == 3'd0);
  // A push into a full FIFO still lands when the sink frees a slot on the same edge.
  assign push_ok  = push_req && (!tx_full || pop);
  assign tx_data  = tx_valid ? tx_mem_q[rd_ptr_q] : 8'h00;
  assign rx_ready = !rx_full_q;
  assign irq      = timer_flag_q && irq_en_q;
  assign tick     = timer_en_q && (presc_q == PRESC_MAX);

  genvar gi;
  generate
    for (gi = 0; gi < TX_DEPTH; gi++) begin : g_tx_mem
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_q == AW'(gi))) begin
          tx_mem_q[gi] <= wdata;
        end
      end
    end
  endgenerate

  always_comb begin
    rdata = 8'h00;
    if (hit) begin
      case (offset)
        3'd1:    rdata = {2'b00, tx_ovf_q, rx_full_q, tx_full, tx_empty,
                          timer_flag_q, timer_en_q};
        3'd2:    rdata = rx_full_q ? rx_byte_q : 8'h00;
        3'd4:    rdata = reload_q;
        3'd5:    rdata = tcount_q;
        3'd6:    rdata = {5'b00000, irq_en_q, 1'b0, timer_en_q};
        default: rdata = 8'h00;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    tx_ovf_d     = tx_ovf_q;
    rx_full_d    = rx_full_q;
    rx_byte_d    = rx_byte_q;
    reload_d     = reload_q;
    tcount_d     = tcount_q;
    presc_d      = presc_q;
    timer_en_d   = timer_en_q;
    irq_en_d     = irq_en_q;
    timer_flag_d = timer_flag_q;
    flag_set     = 1'b0;

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);

    if (wr_en && offset == 3'd1 && wdata[5]) tx_ovf_d = 1'b0;
    if (push_req && tx_full && !pop)         tx_ovf_d = 1'b1;

    // Capture only happens while empty, so it cannot collide with a pending byte.
    if (wr_en && offset == 3'd3) rx_full_d = 1'b0;
    if (rx_valid && !rx_full_q) begin
      rx_full_d = 1'b1;
      rx_byte_d = rx_data;
    end

    if (timer_en_q) presc_d = tick ? '0 : presc_q + PW'(1);
    if (tick) begin
      if (tcount_q == 8'd0) begin
        tcount_d = reload_q;
        flag_set = (reload_q == 8'd0);
      end else begin
        tcount_d = tcount_q - 8'd1;
        flag_set = (tcount_q == 8'd1);
      end
    end

    if (wr_en && offset == 3'd6) begin
      timer_en_d = wdata[0];
      irq_en_d   = wdata[2];
      if (wdata[1]) timer_flag_d = 1'b0;
    end
    if (flag_set) timer_flag_d = 1'b1;

    if (wr_en && offset == 3'd4) begin
      reload_d = wdata;
      tcount_d = wdata;
      presc_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tx_ovf_q     <= 1'b0;
      rx_full_q    <= 1'b0;
      rx_byte_q    <= 8'h00;
      reload_q     <= 8'h00;
      tcount_q     <= 8'h00;
      presc_q      <= '0;
      timer_en_q   <= 1'b0;
      irq_en_q     <= 1'b0;
      timer_flag_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tx_ovf_q     <= tx_ovf_d;
      rx_full_q    <= rx_full_d;
      rx_byte_q    <= rx_byte_d;
      reload_q     <= reload_d;
      tcount_q     <= tcount_d;
      presc_q      <= presc_d;
      timer_en_q   <= timer_en_d;
      irq_en_q     <= irq_en_d;
      timer_flag_q <= timer_flag_d;
    end
  end

endmodule

// File: tb/tb_dj8_io_responder.sv
// Self-checking bench for dj8_io_responder; TX bytes are tracked through a
// scoreboard queue and compared as the sink pops them.
module tb_dj8_io_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic        we;
  logic        hit;
  logic [7:0]  rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  dj8_io_responder #(.BASE(16'hFF00), .TX_DEPTH(4), .PRESCALE(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .wdata(wdata), .we(we),
    .hit(hit), .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted sink handshake must match the oldest expected byte.
  always @(negedge clk) begin
    if (reset_n && tx_valid && tx_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL tx_pop: got %h with no byte expected", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) $display("FAIL tx_pop: got %h expected %h", tx_data, e);
        else begin
          n_pass++;
          $display("tx pop %h", tx_data);
        end
      end
    end
  end

  // One CPU store; called shortly after a rising edge, commits on the next one.
  task automatic store(input logic [15:0] a, input logic [7:0] d);
    address = a;
    wdata   = d;
    we      = 1'b0;
    @(posedge clk);
    #1 we = 1'b1;
    $display("store %h <= %h", a, d);
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    address = a;
    #1 d = rdata;
  endtask

  task automatic drain();
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && (tx_valid || exp_q.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (tx_valid !== 1'b0 || exp_q.size() != 0)
      $display("FAIL drain: tx_valid %b left %0d expected 0 and 0", tx_valid, exp_q.size());
    else n_pass++;
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset_n = 1'b0; we = 1'b1; address = 16'h0000; wdata = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rd(16'hFF01, d);
    n_checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || irq !== 1'b0)
      $display("FAIL reset_out: got v%b r%b i%b expected v0 r1 i0", tx_valid, rx_ready, irq);
    else n_pass++;
    n_checks++;
    if (d !== 8'h04) $display("FAIL reset_status: got %h expected 04", d);
    else n_pass++;
    reset_n = 1'b1;
    @(posedge clk);
    #1 $display("reset released");
  endtask

  task automatic test_tx();
    tx_ready = 1'b0;
    store(16'hFF00, 8'hA5); exp_q.push_back(8'hA5);
    store(16'hFF00, 8'h5A); exp_q.push_back(8'h5A);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5)
      $display("FAIL tx_head: got v%b %h expected v1 a5", tx_valid, tx_data);
    else n_pass++;
    drain();
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      store(16'hFF00, 8'(8'h11 * (i + 1)));
      if (i < 4) exp_q.push_back(8'(8'h11 * (i + 1)));
    end
    rd(16'hFF01, d);
    n_checks++;
    if (d !== 8'h28) $display("FAIL ovf_status: got %h expected 28", d);
    else n_pass++;
    store(16'hFF01, 8'h20);
    rd(16'hFF01, d);
    n_checks++;
    if (d !== 8'h08) $display("FAIL ovf_clear: got %h expected 08", d);
    else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      store(16'hFF00, 8'(8'hC0 + i));
      exp_q.push_back(8'(8'hC0 + i));
    end
    exp_q.push_back(8'hC4);
    tx_ready = 1'b1;
    store(16'hFF00, 8'hC4);
    rd(16'hFF01, d);
    n_checks++;
    if (d[5] !== 1'b0) $display("FAIL full_push_pop_ovf: got %b expected 0", d[5]);
    else n_pass++;
    drain();
  endtask

  task automatic test_rx();
    logic [7:0] d;
    rx_data = 8'h3C; rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_data = 8'h77;
    rd(16'hFF02, d);
    n_checks++;
    if (rx_ready !== 1'b0 || d !== 8'h3C)
      $display("FAIL rx_capture: got r%b %h expected r0 3c", rx_ready, d);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rd(16'hFF02, d);
    n_checks++;
    if (d !== 8'h3C) $display("FAIL rx_hold: got %h expected 3c", d);
    else n_pass++;
    store(16'hFF03, 8'h00);
    n_checks++;
    if (rx_ready !== 1'b1) $display("FAIL rx_ack: got %b expected 1", rx_ready);
    else n_pass++;
    @(posedge clk);
    #1 rd(16'hFF02, d);
    n_checks++;
    if (rx_ready !== 1'b0 || d !== 8'h77)
      $display("FAIL rx_second: got r%b %h expected r0 77", rx_ready, d);
    else n_pass++;
    rx_valid = 1'b0;
    store(16'hFF03, 8'hFF);
    rd(16'hFF02, d);
    n_checks++;
    if (rx_ready !== 1'b1 || d !== 8'h00)
      $display("FAIL rx_empty: got r%b %h expected r1 00", rx_ready, d);
    else n_pass++;
  endtask

  task automatic test_timer();
    logic [7:0] s, c;
    store(16'hFF04, 8'h02);
    store(16'hFF06, 8'h05);
    rd(16'hFF05, c);
    n_checks++;
    if (c !== 8'h02) $display("FAIL timer_load: got %h expected 02", c);
    else n_pass++;
    repeat (7) @(posedge clk);
    #1 rd(16'hFF01, s);
    n_checks++;
    if (s !== 8'h05 || irq !== 1'b0)
      $display("FAIL timer_early: got %h irq %b expected 05 irq 0", s, irq);
    else n_pass++;
    @(posedge clk);
    #1 rd(16'hFF01, s);
    rd(16'hFF05, c);
    n_checks++;
    if (s !== 8'h07 || irq !== 1'b1 || c !== 8'h00)
      $display("FAIL timer_fire: got %h irq %b cnt %h expected 07 irq 1 cnt 00", s, irq, c);
    else n_pass++;
    repeat (4) @(posedge clk);
    #1 rd(16'hFF05, c);
    n_checks++;
    if (c !== 8'h02) $display("FAIL timer_reload: got %h expected 02", c);
    else n_pass++;
    store(16'hFF06, 8'h07);
    rd(16'hFF01, s);
    n_checks++;
    if (s !== 8'h05 || irq !== 1'b0)
      $display("FAIL timer_clear: got %h irq %b expected 05 irq 0", s, irq);
    else n_pass++;
    repeat (6) @(posedge clk);
    #1 store(16'hFF06, 8'h07);
    rd(16'hFF01, s);
    n_checks++;
    if (s !== 8'h07 || irq !== 1'b1)
      $display("FAIL timer_set_wins: got %h irq %b expected 07 irq 1", s, irq);
    else n_pass++;
    store(16'hFF06, 8'h01);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL irq_mask: got %b expected 0", irq);
    else n_pass++;
    store(16'hFF06, 8'h00);
  endtask

  task automatic test_nonhit();
    logic [7:0] s0, s1;
    rd(16'hFF01, s0);
    store(16'hFEFF, 8'h99);
    store(16'hFF08, 8'h99);
    address = 16'hFEFF;
    #1;
    n_checks++;
    if (hit !== 1'b0 || rdata !== 8'h00)
      $display("FAIL nonhit_low: got hit %b %h expected hit 0 00", hit, rdata);
    else n_pass++;
    address = 16'hFF08;
    #1;
    n_checks++;
    if (hit !== 1'b0 || rdata !== 8'h00 || tx_valid !== 1'b0)
      $display("FAIL nonhit_high: got hit %b %h v%b expected hit 0 00 v0", hit, rdata, tx_valid);
    else n_pass++;
    rd(16'hFF01, s1);
    n_checks++;
    if (s1 !== s0 || hit !== 1'b1) $display("FAIL nonhit_state: got %h expected %h", s1, s0);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [7:0] c;
    tx_ready = 1'b0;
    store(16'hFF00, 8'hEE);
    address = 16'hFF04; wdata = 8'h09; we = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete();
    n_checks++;
    if (tx_valid !== 1'b0) $display("FAIL async_reset: got %b expected 0", tx_valid);
    else n_pass++;
    @(posedge clk);
    #3 reset_n = 1'b1; we = 1'b1;
    @(posedge clk);
    #1 rd(16'hFF05, c);
    n_checks++;
    if (c !== 8'h00) $display("FAIL reset_lost_write: got %h expected 00", c);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tx();
    test_overflow();
    test_back_to_back();
    test_rx();
    test_timer();
    test_nonhit();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
